// File: rtl/vscale_hpm_counters.sv
// rtl/vscale_hpm_counters.sv - event-selectable HPM counter bank on the CSR bus; HPM_USER_READ_EN adds user read-only shadows
module vscale_hpm_counters #(
   parameter int N_COUNTERS = 4,
   parameter int CNT_WIDTH  = 64,
   parameter int N_EVENTS   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [11:0]         addr,
   input  logic [2:0]          cmd,
   input  logic [31:0]         wdata,
   input  logic [1:0]          prv,
   input  logic [N_EVENTS-1:0] events,
   output logic [31:0]         rdata,
   output logic                hit,
   output logic                illegal_access,
   output logic                overflow_irq
);

   localparam int SEL_W = $clog2(N_EVENTS);
   localparam int HI_W  = CNT_WIDTH - 32;

   logic [CNT_WIDTH-1:0]  cnt_q [N_COUNTERS];
   logic [SEL_W-1:0]      sel_q [N_COUNTERS];
   logic [N_COUNTERS-1:0] ovf_ie_q;
   logic [N_COUNTERS-1:0] inhibit_q;
   logic [N_COUNTERS-1:0] ovf_q;
   logic [N_EVENTS-1:0]   events_q;

   logic [N_COUNTERS-1:0] dec_lo, dec_hi, dec_ev, dec_ulo, dec_uhi;
   logic                  dec_inh, dec_ovf;
   logic                  is_write, violation, do_wr;
   logic [31:0]           wval;

   logic [N_COUNTERS-1:0] ev_hit, inc, wr_lo, wr_hi, hw_ovf;
   logic [N_COUNTERS-1:0] ovf_next;

   always_comb begin
      dec_lo  = '0;
      dec_hi  = '0;
      dec_ev  = '0;
      dec_ulo = '0;
      dec_uhi = '0;
      for (int i = 0; i < N_COUNTERS; i++) begin
         dec_lo[i] = (addr == 12'hB03 + 12'(i));
         dec_hi[i] = (addr == 12'hB83 + 12'(i));
         dec_ev[i] = (addr == 12'h323 + 12'(i));
`ifdef HPM_USER_READ_EN
         dec_ulo[i] = (addr == 12'hC03 + 12'(i));
         dec_uhi[i] = (addr == 12'hC83 + 12'(i));
`endif
      end
      dec_inh = (addr == 12'h320);
      dec_ovf = (addr == 12'h7C0);
   end

   assign hit = (|dec_lo) | (|dec_hi) | (|dec_ev) | (|dec_ulo) | (|dec_uhi) | dec_inh | dec_ovf;

   // Read-only space is addr[11:10]==2'b11; minimum privilege sits in addr[9:8].
   assign is_write       = cmd[1] | cmd[0];
   assign violation      = (is_write && (addr[11:10] == 2'b11)) || (addr[9:8] > prv);
   assign illegal_access = cmd[2] && hit && violation;
   assign do_wr          = cmd[2] && is_write && hit && !violation;

   always_comb begin
      rdata = '0;
      for (int i = 0; i < N_COUNTERS; i++) begin
         if (dec_lo[i] || dec_ulo[i])
            rdata = rdata | cnt_q[i][31:0];
         if (dec_hi[i] || dec_uhi[i])
            rdata = rdata | 32'(cnt_q[i][CNT_WIDTH-1:32]);
         if (dec_ev[i])
            rdata = rdata | {ovf_ie_q[i], 31'(sel_q[i])};
      end
      if (dec_inh)
         rdata = rdata | 32'({inhibit_q, 3'b000});
      if (dec_ovf)
         rdata = rdata | 32'(ovf_q);
   end

   always_comb begin
      case (cmd[1:0])
         2'b10:   wval = rdata | wdata;
         2'b11:   wval = rdata & ~wdata;
         default: wval = wdata;
      endcase
   end

   // Out-of-range select values match no event index and therefore never count.
   always_comb begin
      ev_hit = '0;
      inc    = '0;
      wr_lo  = '0;
      wr_hi  = '0;
      hw_ovf = '0;
      for (int i = 0; i < N_COUNTERS; i++) begin
         for (int e = 0; e < N_EVENTS; e++) begin
            if (sel_q[i] == SEL_W'(e))
               ev_hit[i] = events_q[e];
         end
         inc[i]    = ev_hit[i] && !inhibit_q[i];
         wr_lo[i]  = do_wr && dec_lo[i];
         wr_hi[i]  = do_wr && dec_hi[i];
         hw_ovf[i] = inc[i] && !wr_lo[i] && !wr_hi[i] && (&cnt_q[i]);
      end
      ovf_next = ((do_wr && dec_ovf) ? wval[N_COUNTERS-1:0] : ovf_q) | hw_ovf;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_COUNTERS; i++) begin
            cnt_q[i] <= '0;
            sel_q[i] <= '0;
         end
         ovf_ie_q     <= '0;
         inhibit_q    <= '0;
         ovf_q        <= '0;
         events_q     <= '0;
         overflow_irq <= 1'b0;
      end else begin
         events_q     <= events;
         ovf_q        <= ovf_next;
         overflow_irq <= |(ovf_q & ovf_ie_q);
         if (do_wr && dec_inh)
            inhibit_q <= wval[N_COUNTERS+2:3];
         for (int i = 0; i < N_COUNTERS; i++) begin
            // A CSR write to either half takes priority and drops that cycle's increment.
            if (wr_lo[i])
               cnt_q[i][31:0] <= wval;
            else if (wr_hi[i])
               cnt_q[i][CNT_WIDTH-1:32] <= wval[HI_W-1:0];
            else if (inc[i])
               cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
            if (do_wr && dec_ev[i]) begin
               sel_q[i]    <= wval[SEL_W-1:0];
               ovf_ie_q[i] <= wval[31];
            end
         end
      end
   end

endmodule

// File: tb/tb_vscale_hpm_counters.sv
// tb/tb_vscale_hpm_counters.sv - directed self-checking bench for vscale_hpm_counters
module tb_vscale_hpm_counters;

   logic        clk;
   logic        reset;
   logic [11:0] addr;
   logic [2:0]  cmd;
   logic [31:0] wdata;
   logic [1:0]  prv;
   logic [5:0]  events;
   logic [31:0] rdata;
   logic        hit;
   logic        illegal_access;
   logic        overflow_irq;

   int n_checks = 0;
   int n_fail   = 0;
   int lat_exp [6] = '{0, 0, 1, 2, 3, 3};

`ifdef HPM_USER_READ_EN
   localparam bit USER_EN = 1'b1;
`else
   localparam bit USER_EN = 1'b0;
`endif

   vscale_hpm_counters #(
      .N_COUNTERS(4),
      .CNT_WIDTH (40),
      .N_EVENTS  (6)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .addr          (addr),
      .cmd           (cmd),
      .wdata         (wdata),
      .prv           (prv),
      .events        (events),
      .rdata         (rdata),
      .hit           (hit),
      .illegal_access(illegal_access),
      .overflow_irq  (overflow_irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic csr_op(input logic [2:0] c, input logic [11:0] a, input logic [31:0] d);
      cmd = c; addr = a; wdata = d;
      @(negedge clk);
      cmd = 3'd0;
   endtask

   task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
      cmd = 3'd4; addr = a;
      #1;
      check_eq(tag, rdata, exp);
      cmd = 3'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd = 3'd0; addr = '0; wdata = '0; prv = 2'd3; events = '0;
      repeat (2) step();
      reset = 1'b0;

      rd_check("rst_cnt", 12'hB03, 32'h0);
      rd_check("rst_evt", 12'h323, 32'h0);
      rd_check("rst_inh", 12'h320, 32'h0);
      rd_check("rst_ovf", 12'h7C0, 32'h0);
      check_eq("rst_irq", overflow_irq, 0);
      cmd = 3'd4; addr = 12'h000; #1;
      check_eq("miss_hit", hit, 0);
      check_eq("miss_rdata", rdata, 0);
      cmd = 3'd0;
      step();

      // event latency: two edges from pulse to visible count
      csr_op(3'd5, 12'h323, 32'h2);
      for (int k = 0; k < 6; k++) begin
         events = (k < 3) ? 6'h04 : 6'h00;
         rd_check("lat_cnt", 12'hB03, lat_exp[k]);
         step();
      end
      rd_check("lat_hi", 12'hB83, 32'h0);
      rd_check("lat_other", 12'hB04, 32'h0);

      // 40-bit wrap, sticky flag and interrupt
      csr_op(3'd5, 12'hB83, 32'hFF);
      csr_op(3'd5, 12'hB03, 32'hFFFF_FFFF);
      csr_op(3'd5, 12'h323, 32'h8000_0002);
      rd_check("wrap_hi_wr", 12'hB83, 32'hFF);
      events = 6'h04; step(); events = 6'h00;
      rd_check("wrap_pre", 12'hB03, 32'hFFFF_FFFF);
      step();
      rd_check("wrap_lo", 12'hB03, 32'h0);
      rd_check("wrap_hi", 12'hB83, 32'h0);
      rd_check("wrap_ovf", 12'h7C0, 32'h1);
      check_eq("wrap_irq_early", overflow_irq, 0);
      step();
      check_eq("wrap_irq", overflow_irq, 1);
      csr_op(3'd7, 12'h7C0, 32'h1);
      rd_check("ovf_clr", 12'h7C0, 32'h0);
      check_eq("irq_hold", overflow_irq, 1);
      step();
      check_eq("irq_fall", overflow_irq, 0);

      // write vs increment collision; hardware ovf set vs CSR clear
      csr_op(3'd5, 12'h324, 32'h1);
      events = 6'h02; step(); events = 6'h00;
      csr_op(3'd5, 12'hB04, 32'h50);
      rd_check("coll_wr", 12'hB04, 32'h50);
      csr_op(3'd5, 12'hB84, 32'hFF);
      csr_op(3'd5, 12'hB04, 32'hFFFF_FFFF);
      events = 6'h02; step(); events = 6'h00;
      csr_op(3'd7, 12'h7C0, 32'hF);
      rd_check("coll_ovf", 12'h7C0, 32'h2);
      rd_check("coll_wrap", 12'hB04, 32'h0);
      step();
      check_eq("irq_no_ie", overflow_irq, 0);

      // select beyond N_EVENTS never counts; multi-hot events
      csr_op(3'd5, 12'h325, 32'h7FFF_FFFF);
      rd_check("evt_rd", 12'h325, 32'h7);
      events = 6'h3F; step(); events = 6'h00;
      step(); step();
      rd_check("sel_oob", 12'hB05, 32'h0);
      rd_check("sel0_cnt", 12'hB06, 32'h1);
      rd_check("multi_c0", 12'hB03, 32'h1);
      rd_check("multi_c1", 12'hB04, 32'h1);

      // privilege and read-only checks
      prv = 2'd0; cmd = 3'd4; addr = 12'hB03; #1;
      check_eq("u_rd_illegal", illegal_access, 1);
      cmd = 3'd0;
      step();
      cmd = 3'd5; addr = 12'hB03; wdata = 32'h99; #1;
      check_eq("u_wr_illegal", illegal_access, 1);
      step(); cmd = 3'd0; prv = 2'd3;
      rd_check("u_wr_nochg", 12'hB03, 32'h1);
      cmd = 3'd5; addr = 12'hC03; wdata = 32'h77; #1;
      check_eq("c03_wr_illegal", illegal_access, USER_EN);
      step(); cmd = 3'd0;
      rd_check("c03_nochg", 12'hB03, 32'h1);

      csr_op(3'd6, 12'h320, 32'h8);
      rd_check("inh_rd", 12'h320, 32'h8);
      events = 6'h06; step(); step(); events = 6'h00;
      step(); step();
      rd_check("inh_frozen", 12'hB03, 32'h1);
      rd_check("inh_other", 12'hB04, 32'h3);

      // user shadow reads
      prv = 2'd0; cmd = 3'd4; addr = 12'hC04; #1;
      check_eq("user_hit", hit, USER_EN);
      check_eq("user_rdata", rdata, USER_EN ? 32'h3 : 32'h0);
      check_eq("user_illegal", illegal_access, 0);
      cmd = 3'd0; prv = 2'd3;
      step();

      // asynchronous reset mid-count
      csr_op(3'd5, 12'h320, 32'h0);
      csr_op(3'd5, 12'hB03, 32'h1234);
      for (int k = 0; k < 4; k++) begin
         events = (k % 2 == 0) ? 6'h04 : 6'h00;
         step();
      end
      rd_check("pre_rst_cnt", 12'hB03, 32'h1236);
      csr_op(3'd5, 12'h324, 32'h8000_0001);
      step();
      check_eq("pre_rst_irq", overflow_irq, 1);
      events = 6'h04;
      #3 reset = 1'b1;
      #1;
      check_eq("rst_async_irq", overflow_irq, 0);
      rd_check("rst_async_cnt", 12'hB03, 32'h0);
      rd_check("rst_async_evt", 12'h324, 32'h0);
      rd_check("rst_async_ovf", 12'h7C0, 32'h0);
      events = 6'h00;
      step();
      reset = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
